// File: rtl/rob_cdb_arbiter.sv
// Common data bus arbiter: four per-source completion FIFOs drained one beat per
// cycle in round-robin order into a registered CDB output stage.
module rob_cdb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                flush,
    input  logic [3:0]          fu_valid,
    output logic [3:0]          fu_ready,
    input  logic [4*TAG_W-1:0]  fu_tag,
    input  logic [4*DATA_W-1:0] fu_result,
    input  logic [4*DATA_W-1:0] fu_aux,
    input  logic [3:0]          fu_taken,
    input  logic                cdb_ready,
    output logic                cdb_valid,
    output logic [1:0]          cdb_src,
    output logic [TAG_W-1:0]    cdb_tag,
    output logic [DATA_W-1:0]   cdb_result,
    output logic [DATA_W-1:0]   cdb_aux,
    output logic                cdb_taken
);

    localparam int unsigned N_SRC = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = TAG_W + 2 * DATA_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] aux;
        logic              taken;
    } entry_t;

    logic [N_SRC-1:0]       not_empty;
    logic [N_SRC-1:0]       push;
    logic [N_SRC-1:0]       pop;
    logic [N_SRC*ENT_W-1:0] head_flat;

    logic       advance;
    logic       pop_fire;
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic [1:0] rr_ptr;
    entry_t     win_entry;

    // Per-source circular FIFO; readiness comes from the registered count only.
    for (genvar g = 0; g < N_SRC; g++) begin : g_fifo
        entry_t            mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        entry_t            in_entry;

        assign in_entry.tag    = fu_tag[TAG_W*g +: TAG_W];
        assign in_entry.result = fu_result[DATA_W*g +: DATA_W];
        assign in_entry.aux    = fu_aux[DATA_W*g +: DATA_W];
        assign in_entry.taken  = fu_taken[g];

        assign fu_ready[g]  = (count < CNT_W'(DEPTH));
        assign not_empty[g] = (count != '0);
        assign push[g]      = fu_valid[g] && fu_ready[g] && !flush;
        assign pop[g]       = pop_fire && (win_idx == 2'(g));
        assign head_flat[ENT_W*g +: ENT_W] = mem[rd_ptr];

        always_ff @(posedge CLK) begin
            if (reset || flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[g], pop[g]})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // Storage needs no reset: count gates every read.
        always_ff @(posedge CLK) begin
            if (push[g] && !reset) begin
                mem[wr_ptr] <= in_entry;
            end
        end
    end

    // Round-robin scan from rr_ptr; descending loop so the nearest candidate wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        cand      = rr_ptr;
        for (int off = N_SRC - 1; off >= 0; off--) begin
            cand = rr_ptr + 2'(off);
            if (not_empty[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign advance   = !cdb_valid || cdb_ready;
    assign pop_fire  = advance && win_found && !flush;
    assign win_entry = entry_t'(head_flat[ENT_W*win_idx +: ENT_W]);

    // Registered CDB stage; a held beat is dropped by flush even under backpressure.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rr_ptr     <= '0;
            cdb_valid  <= 1'b0;
            cdb_src    <= '0;
            cdb_tag    <= '0;
            cdb_result <= '0;
            cdb_aux    <= '0;
            cdb_taken  <= 1'b0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (advance) begin
            if (win_found) begin
                cdb_valid  <= 1'b1;
                cdb_src    <= win_idx;
                cdb_tag    <= win_entry.tag;
                cdb_result <= win_entry.result;
                cdb_aux    <= win_entry.aux;
                cdb_taken  <= win_entry.taken;
                rr_ptr     <= win_idx + 2'd1;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rob_cdb_arbiter.sv
// Directed bench for rob_cdb_arbiter; a negedge monitor scoreboards every accepted
// push against every consumed CDB beat, per source in FIFO order.
module tb_rob_cdb_arbiter;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    logic                CLK = 1'b0;
    logic                reset;
    logic                flush;
    logic [3:0]          fu_valid;
    logic [3:0]          fu_ready;
    logic [4*TAG_W-1:0]  fu_tag;
    logic [4*DATA_W-1:0] fu_result;
    logic [4*DATA_W-1:0] fu_aux;
    logic [3:0]          fu_taken;
    logic                cdb_ready;
    logic                cdb_valid;
    logic [1:0]          cdb_src;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_result;
    logic [DATA_W-1:0]   cdb_aux;
    logic                cdb_taken;

    typedef struct {
        logic [1:0]        src;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] aux;
        logic              taken;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   hit;
    int   checks = 0;
    int   errors = 0;

    rob_cdb_arbiter #(.DEPTH(2), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .flush      (flush),
        .fu_valid   (fu_valid),
        .fu_ready   (fu_ready),
        .fu_tag     (fu_tag),
        .fu_result  (fu_result),
        .fu_aux     (fu_aux),
        .fu_taken   (fu_taken),
        .cdb_ready  (cdb_ready),
        .cdb_valid  (cdb_valid),
        .cdb_src    (cdb_src),
        .cdb_tag    (cdb_tag),
        .cdb_result (cdb_result),
        .cdb_aux    (cdb_aux),
        .cdb_taken  (cdb_taken)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_src(input int i, input logic [TAG_W-1:0] tag,
                           input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] aux,
                           input logic tk);
        fu_valid[i]                  = 1'b1;
        fu_tag[TAG_W*i +: TAG_W]     = tag;
        fu_result[DATA_W*i +: DATA_W] = res;
        fu_aux[DATA_W*i +: DATA_W]    = aux;
        fu_taken[i]                  = tk;
    endtask

    task automatic idle();
        fu_valid = '0;
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] src, input logic [TAG_W-1:0] t);
        chk({tag, "_valid"}, 64'(cdb_valid), 64'(1));
        chk({tag, "_src"}, 64'(cdb_src), 64'(src));
        chk({tag, "_tag"}, 64'(cdb_tag), 64'(t));
    endtask

    // Scoreboard: record accepted pushes, match consumed beats, drop all on flush/reset.
    always @(negedge CLK) begin
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (cdb_valid && cdb_ready) begin
                hit = -1;
                for (int j = sb.size() - 1; j >= 0; j--) begin
                    if (sb[j].src == cdb_src) hit = j;
                end
                chk("beat_expected", 64'(hit >= 0), 64'(1));
                if (hit >= 0) begin
                    chk("sb_tag", 64'(cdb_tag), 64'(sb[hit].tag));
                    chk("sb_result", 64'(cdb_result), 64'(sb[hit].result));
                    chk("sb_aux", 64'(cdb_aux), 64'(sb[hit].aux));
                    chk("sb_taken", 64'(cdb_taken), 64'(sb[hit].taken));
                    sb.delete(hit);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    e.src    = 2'(i);
                    e.tag    = fu_tag[TAG_W*i +: TAG_W];
                    e.result = fu_result[DATA_W*i +: DATA_W];
                    e.aux    = fu_aux[DATA_W*i +: DATA_W];
                    e.taken  = fu_taken[i];
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; cdb_ready = 1'b1;
        fu_valid = '0; fu_tag = '0; fu_result = '0; fu_aux = '0; fu_taken = '0;
        tick(); tick();
        chk("rst_valid", 64'(cdb_valid), 64'(0));
        chk("rst_src", 64'(cdb_src), 64'(0));
        chk("rst_tag", 64'(cdb_tag), 64'(0));
        chk("rst_result", 64'(cdb_result), 64'(0));
        chk("rst_aux", 64'(cdb_aux), 64'(0));
        chk("rst_taken", 64'(cdb_taken), 64'(0));
        reset = 1'b0;
        tick();
        chk("rst_ready", 64'(fu_ready), 64'hf);

        // Single beat with one-cycle latency and no bypass
        set_src(2, 4'd5, 32'h1234, 32'h0, 1'b0);
        tick(); idle();
        chk("single_no_bypass", 64'(cdb_valid), 64'(0));
        tick();
        chk_beat("single", 2'd2, 4'd5);
        chk("single_result", 64'(cdb_result), 64'h1234);
        tick();
        chk("single_done", 64'(cdb_valid), 64'(0));

        // Fairness from rr_ptr=0, then from rr_ptr=1
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 4'(i + 1), 32'h100 + i, 32'h200 + i, 1'(i));
        tick(); idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_beat("fair0", 2'(k), 4'(k + 1));
        end
        set_src(0, 4'd9, 32'h9, 32'h99, 1'b1);
        tick(); idle();
        tick();
        chk_beat("fair_pre", 2'd0, 4'd9);
        for (int i = 0; i < 4; i++) set_src(i, 4'(i + 5), 32'h500 + i, 32'h600 + i, 1'(i + 1));
        tick(); idle();
        chk("fair1_gap", 64'(cdb_valid), 64'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_beat("fair1", 2'((k + 1) % 4), 4'(((k + 1) % 4) + 5));
        end
        tick();
        chk("fair1_done", 64'(cdb_valid), 64'(0));

        // Backpressure: tag 7 held while source 0 fills up
        set_src(1, 4'd7, 32'h77, 32'h770, 1'b1);
        tick(); idle();
        cdb_ready = 1'b0;
        tick();
        chk_beat("bp_load", 2'd1, 4'd7);
        set_src(0, 4'd10, 32'hA0, 32'hA1, 1'b0);
        tick();
        chk_beat("bp_hold1", 2'd1, 4'd7);
        chk("bp_ready1", 64'(fu_ready[0]), 64'(1));
        set_src(0, 4'd11, 32'hB0, 32'hB1, 1'b1);
        tick();
        chk_beat("bp_hold2", 2'd1, 4'd7);
        chk("bp_full", 64'(fu_ready[0]), 64'(0));
        set_src(0, 4'd12, 32'hC0, 32'hC1, 1'b0);
        tick();
        chk_beat("bp_hold3", 2'd1, 4'd7);
        chk("bp_still_full", 64'(fu_ready[0]), 64'(0));
        tick();
        chk_beat("bp_hold4", 2'd1, 4'd7);
        cdb_ready = 1'b1;
        tick();
        chk_beat("bp_drain10", 2'd0, 4'd10);
        chk("bp_ready_again", 64'(fu_ready[0]), 64'(1));
        tick(); idle();
        chk_beat("bp_drain11", 2'd0, 4'd11);
        tick();
        chk_beat("bp_drain12", 2'd0, 4'd12);
        tick();
        chk("bp_done", 64'(cdb_valid), 64'(0));

        // Full FIFO 1 with a simultaneous pop refuses the push that cycle
        cdb_ready = 1'b0;
        set_src(1, 4'd3, 32'h3, 32'h30, 1'b0);
        tick();
        set_src(1, 4'd4, 32'h4, 32'h40, 1'b0);
        tick();
        chk_beat("full_load", 2'd1, 4'd3);
        set_src(1, 4'd5, 32'h5, 32'h50, 1'b1);
        tick();
        chk("full_ready0", 64'(fu_ready[1]), 64'(0));
        set_src(1, 4'd6, 32'h6, 32'h60, 1'b0);
        cdb_ready = 1'b1;
        tick();
        chk_beat("full_pop4", 2'd1, 4'd4);
        chk("full_ready1", 64'(fu_ready[1]), 64'(1));
        tick(); idle();
        chk_beat("full_pop5", 2'd1, 4'd5);
        tick();
        chk_beat("full_pop6", 2'd1, 4'd6);
        tick();
        chk("full_done", 64'(cdb_valid), 64'(0));

        // Flush under backpressure with a same-cycle push
        cdb_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_src(i, 4'(i + 1), 32'hF0 + i, 32'hF1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) set_src(i, 4'(i + 4), 32'hE0 + i, 32'hE1, 1'b1);
        tick(); idle();
        chk_beat("flush_pre", 2'd2, 4'd3);
        set_src(3, 4'd15, 32'hFF, 32'hFE, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0; idle();
        chk("flush_valid", 64'(cdb_valid), 64'(0));
        chk("flush_ready", 64'(fu_ready), 64'hf);
        cdb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_silent", 64'(cdb_valid), 64'(0));
        end

        // Reset mid-stream, then fresh round-robin from 0
        for (int i = 0; i < 4; i++) set_src(i, 4'(i + 8), 32'h8000 + i, 32'hDEAD0000 + i, 1'b1);
        tick(); idle();
        tick();
        chk_beat("rs_beat3", 2'd3, 4'd11);
        tick();
        chk_beat("rs_beat0", 2'd0, 4'd8);
        chk("rs_aux0", 64'(cdb_aux), 64'hDEAD0000);
        reset = 1'b1;
        tick();
        chk("rs_valid", 64'(cdb_valid), 64'(0));
        chk("rs_src", 64'(cdb_src), 64'(0));
        chk("rs_tag", 64'(cdb_tag), 64'(0));
        chk("rs_result", 64'(cdb_result), 64'(0));
        chk("rs_aux", 64'(cdb_aux), 64'(0));
        chk("rs_taken", 64'(cdb_taken), 64'(0));
        reset = 1'b0;
        tick();
        chk("rs_quiet", 64'(cdb_valid), 64'(0));
        chk("rs_ready", 64'(fu_ready), 64'hf);
        set_src(3, 4'd13, 32'hD3, 32'hD4, 1'b1);
        set_src(0, 4'd12, 32'hC3, 32'hC4, 1'b0);
        tick(); idle();
        tick();
        chk_beat("rs_fresh0", 2'd0, 4'd12);
        tick();
        chk_beat("rs_fresh3", 2'd3, 4'd13);
        tick();
        chk("rs_done", 64'(cdb_valid), 64'(0));

        tick();
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
